// File: rtl/sdram_test_gen.sv
// sdram_test_gen: self-checking traffic generator for the SDRAM read/write test.
//
// Once the SDRAM controller reports init_done, writes the incrementing pattern
// 1..TEST_LEN into the controller's write FIFO, reads the same number of words
// back from the read FIFO and compares each one. Status on the board LED:
// solid on = pass, blinking with half-period BLINK_HALF cycles = error.
//
// Optional build macro: SDRAM_TEST_ERRCNT_EN adds a saturating 16-bit
// mismatch counter on output err_cnt.
//
// Ports:
//   clk, rst           test clock, synchronous active-high reset
//   init_done          controller initialisation complete
//   wr_full            write FIFO full
//   wr_en, wr_data     write strobe / data to the write FIFO
//   rd_empty           read FIFO empty
//   rd_en, rd_data     read strobe / data (data valid the cycle after rd_en)
//   test_done          all TEST_LEN words compared
//   error_flag         sticky mismatch flag
//   err_cnt            mismatch count (SDRAM_TEST_ERRCNT_EN builds only)
//   led                status LED
module sdram_test_gen #(
    parameter int DATA_W     = 16,
    parameter int TEST_LEN   = 1024,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              test_done,
    output logic              error_flag,
`ifdef SDRAM_TEST_ERRCNT_EN
    output logic [15:0]       err_cnt,
`endif
    output logic              led
);

    localparam logic [15:0]   LEN       = 16'(TEST_LEN);
    localparam int            BW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t            state, state_nxt;
    logic [15:0]       wr_cnt;
    logic [15:0]       rd_issued;
    logic [15:0]       chk_cnt;
    logic              rd_valid;
    logic [BW-1:0]     blink_cnt;
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    assign exp_data  = DATA_W'(chk_cnt + 16'd1);
    assign mismatch  = (rd_data != exp_data);
    assign test_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // rd_en is combinational on rd_empty so a read can never be issued in a
    // cycle where the FIFO reports empty.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE:  if (init_done) state_nxt = WRITE;
            WRITE: if (wr_cnt == LEN) state_nxt = READ;
            READ: begin
                rd_en = !rd_empty && (rd_issued < LEN);
                if (chk_cnt == LEN) state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_cnt     <= '0;
            rd_issued  <= '0;
            chk_cnt    <= '0;
            rd_valid   <= 1'b0;
            error_flag <= 1'b0;
            led        <= 1'b0;
            blink_cnt  <= '0;
        end else begin
            // wr_en follows the wr_full sampled at this edge; the word is only
            // advanced when a write is actually issued.
            wr_en <= 1'b0;
            if (state == WRITE && !wr_full && wr_cnt < LEN) begin
                wr_en   <= 1'b1;
                wr_data <= DATA_W'(wr_cnt + 16'd1);
                wr_cnt  <= wr_cnt + 16'd1;
            end

            rd_valid <= rd_en;
            if (rd_en) rd_issued <= rd_issued + 16'd1;
            if (rd_valid) begin
                chk_cnt <= chk_cnt + 16'd1;
                if (mismatch) error_flag <= 1'b1;
            end

            if (state == DONE) begin
                if (!error_flag) begin
                    led <= 1'b1;
                end else if (blink_cnt == BLINK_MAX) begin
                    blink_cnt <= '0;
                    led       <= ~led;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                led       <= 1'b0;
                blink_cnt <= '0;
            end
        end
    end

`ifdef SDRAM_TEST_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                          err_cnt <= '0;
        else if (rd_valid && mismatch && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sdram_test_gen.sv
// Bench for sdram_test_gen. Two instances: inst 0 with TEST_LEN=8 and inst 1
// with TEST_LEN=1, both BLINK_HALF=4. A behavioural FIFO model (array store
// with pointers) sits behind each instance, checks the strobe rules and the
// write pattern, and can inject a corrupt read word or random empty/full gaps.
module tb_sdram_test_gen;

    logic        clk;
    logic        rst_a       [2];
    logic        init_done_a [2];
    logic        wr_full_a   [2];
    logic        wr_en_a     [2];
    logic [15:0] wr_data_a   [2];
    logic        rd_empty_a  [2];
    logic        rd_en_a     [2];
    logic [15:0] rd_data_a   [2];
    logic        test_done_a [2];
    logic        error_flag_a[2];
    logic        led_a       [2];
`ifdef SDRAM_TEST_ERRCNT_EN
    logic [15:0] err_cnt_a   [2];
`endif

    int total = 0;
    int bad   = 0;

    // model state
    int          nwr[2], nrd[2], wp[2], rp[2], corrupt_idx[2];
    bit          empty_tog[2];
    bit          empty_rand[2];
    logic [15:0] mem[2][64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sdram_test_gen #(.DATA_W(16), .TEST_LEN(8), .BLINK_HALF(4)) dut (
        .clk(clk), .rst(rst_a[0]), .init_done(init_done_a[0]),
        .wr_full(wr_full_a[0]), .wr_en(wr_en_a[0]), .wr_data(wr_data_a[0]),
        .rd_empty(rd_empty_a[0]), .rd_en(rd_en_a[0]), .rd_data(rd_data_a[0]),
        .test_done(test_done_a[0]), .error_flag(error_flag_a[0]),
`ifdef SDRAM_TEST_ERRCNT_EN
        .err_cnt(err_cnt_a[0]),
`endif
        .led(led_a[0]));

    sdram_test_gen #(.DATA_W(16), .TEST_LEN(1), .BLINK_HALF(4)) dut1 (
        .clk(clk), .rst(rst_a[1]), .init_done(init_done_a[1]),
        .wr_full(wr_full_a[1]), .wr_en(wr_en_a[1]), .wr_data(wr_data_a[1]),
        .rd_empty(rd_empty_a[1]), .rd_en(rd_en_a[1]), .rd_data(rd_data_a[1]),
        .test_done(test_done_a[1]), .error_flag(error_flag_a[1]),
`ifdef SDRAM_TEST_ERRCNT_EN
        .err_cnt(err_cnt_a[1]),
`endif
        .led(led_a[1]));

    function automatic int len(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // FIFO model: strobes sampled at the falling edge, FIFO updates applied
    // just after the rising edge that consumes them.
    task automatic fifo_model();
        logic        dw[2], dr[2], pf[2], rs[2];
        logic [15:0] wd[2];
        bit          ph;
        ph = 1'b0;
        pf = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                dw[i] = wr_en_a[i];
                wd[i] = wr_data_a[i];
                dr[i] = rd_en_a[i];
                rs[i] = rst_a[i];
                if (!rs[i]) begin
                    if (dr[i]) chk("rd_while_empty", {31'd0, rd_empty_a[i]}, 32'd0);
                    if (dw[i]) chk("wr_after_full", {31'd0, pf[i]}, 32'd0);
                end
                pf[i] = rs[i] ? 1'b0 : wr_full_a[i];
            end
            @(posedge clk);
            #1;
            ph = ~ph;
            for (int i = 0; i < 2; i++) begin
                if (rs[i]) begin
                    nwr[i] = 0; nrd[i] = 0; wp[i] = 0; rp[i] = 0;
                end else begin
                    if (dw[i]) begin
                        chk("wr_pattern", {16'd0, wd[i]}, nwr[i] + 1);
                        chk("wr_overrun", {31'd0, nwr[i] < len(i)}, 32'd1);
                        if (wp[i] < 64) mem[i][wp[i]] = wd[i];
                        wp[i]++;
                        nwr[i]++;
                    end
                    if (dr[i]) begin
                        chk("rd_overrun", {31'd0, nrd[i] < len(i)}, 32'd1);
                        nrd[i]++;
                        rd_data_a[i] = (rp[i] < 64) ? mem[i][rp[i]] : 16'hDEAD;
                        if (nrd[i] == corrupt_idx[i]) rd_data_a[i] = 16'h00FF;
                        rp[i]++;
                    end
                end
                rd_empty_a[i] = (wp[i] <= rp[i]) || (empty_tog[i] && ph) ||
                                (empty_rand[i] && ($urandom_range(0, 2) == 0));
            end
        end
    endtask

    task automatic restart0();
        rst_a[0] = 1'b1;
        tick();
        tick();
        rst_a[0] = 1'b0;
    endtask

    task automatic run_and_check(input int i, input bit exp_err, input string tag);
        int b = 0;
        while (test_done_a[i] !== 1'b1 && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "_done"}, {31'd0, test_done_a[i]}, 32'd1);
        chk({tag, "_err"}, {31'd0, error_flag_a[i]}, {31'd0, exp_err});
        chk({tag, "_nwr"}, nwr[i], len(i));
        chk({tag, "_nrd"}, nrd[i], len(i));
        repeat (3) @(negedge clk);
        if (!exp_err) chk({tag, "_led"}, {31'd0, led_a[i]}, 32'd1);
    endtask

    task automatic wait_cnt(input int i, input bit rd, input int n);
        int b = 0;
        while ((rd ? nrd[i] : nwr[i]) < n && b < 500) begin
            tick();
            b++;
        end
        chk("wait_progress", {31'd0, (rd ? nrd[i] : nwr[i]) >= n}, 32'd1);
    endtask

    initial begin
        int strobes;
        int last, togs;
        logic pl;
        rst_a       = '{1'b1, 1'b1};
        init_done_a = '{1'b0, 1'b0};
        wr_full_a   = '{1'b0, 1'b0};
        rd_empty_a  = '{1'b1, 1'b1};
        rd_data_a   = '{16'd0, 16'd0};
        corrupt_idx = '{0, 0};
        empty_tog   = '{1'b0, 1'b0};
        empty_rand  = '{1'b0, 1'b0};
        nwr = '{0, 0}; nrd = '{0, 0}; wp = '{0, 0}; rp = '{0, 0};
        fork
            fifo_model();
        join_none

        repeat (3) tick();
        @(negedge clk);
        chk("rst_wr_en",   {31'd0, wr_en_a[0]},      32'd0);
        chk("rst_wr_data", {16'd0, wr_data_a[0]},    32'd0);
        chk("rst_rd_en",   {31'd0, rd_en_a[0]},      32'd0);
        chk("rst_done",    {31'd0, test_done_a[0]},  32'd0);
        chk("rst_err",     {31'd0, error_flag_a[0]}, 32'd0);
        chk("rst_led",     {31'd0, led_a[0]},        32'd0);
`ifdef SDRAM_TEST_ERRCNT_EN
        chk("rst_err_cnt", {16'd0, err_cnt_a[0]},    32'd0);
`endif

        // 1: plain pass, init_done after 100 cycles
        tick();
        rst_a[0] = 1'b0;
        strobes = 0;
        repeat (100) begin
            @(negedge clk);
            if (wr_en_a[0] || rd_en_a[0]) strobes++;
        end
        chk("idle_strobes", strobes, 0);
        tick();
        init_done_a[0] = 1'b1;
        run_and_check(0, 1'b0, "t1");
`ifdef SDRAM_TEST_ERRCNT_EN
        chk("t1_err_cnt", {16'd0, err_cnt_a[0]}, 32'd0);
`endif

        // 2: wr_full high for 5 cycles after the third write
        restart0();
        wait_cnt(0, 1'b0, 3);
        wr_full_a[0] = 1'b1;
        repeat (5) tick();
        chk("t2_stall_hold", nwr[0], 4);
        wr_full_a[0] = 1'b0;
        run_and_check(0, 1'b0, "t2");

        // 3: third read word corrupted, LED must blink every 4 cycles
        corrupt_idx[0] = 3;
        restart0();
        run_and_check(0, 1'b1, "t3");
        last = -1;
        togs = 0;
        pl   = led_a[0];
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (led_a[0] !== pl) begin
                if (last >= 0) chk("t3_blink_period", c - last, 4);
                last = c;
                togs++;
                pl = led_a[0];
            end
        end
        chk("t3_blink_count", {31'd0, togs >= 5}, 32'd1);
        chk("t3_err_sticky", {31'd0, error_flag_a[0]}, 32'd1);
`ifdef SDRAM_TEST_ERRCNT_EN
        chk("t3_err_cnt", {16'd0, err_cnt_a[0]}, 32'd1);
`endif
        corrupt_idx[0] = 0;

        // 4: rd_empty toggling, init_done dropped mid-write (ignored)
        empty_tog[0] = 1'b1;
        restart0();
        wait_cnt(0, 1'b0, 1);
        init_done_a[0] = 1'b0;
        run_and_check(0, 1'b0, "t4");
        empty_tog[0]   = 1'b0;
        init_done_a[0] = 1'b1;

        // 4b: random empty gaps and random write backpressure
        empty_rand[0] = 1'b1;
        restart0();
        for (int c = 0; c < 40; c++) begin
            wr_full_a[0] = ($urandom_range(0, 1) == 1);
            tick();
        end
        wr_full_a[0] = 1'b0;
        run_and_check(0, 1'b0, "t4b");
        empty_rand[0] = 1'b0;

        // 5: reset during READ after 4 reads, then rerun
        restart0();
        wait_cnt(0, 1'b1, 4);
        rst_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_wr_en",   {31'd0, wr_en_a[0]},      32'd0);
        chk("t5_wr_data", {16'd0, wr_data_a[0]},    32'd0);
        chk("t5_rd_en",   {31'd0, rd_en_a[0]},      32'd0);
        chk("t5_done",    {31'd0, test_done_a[0]},  32'd0);
        chk("t5_err",     {31'd0, error_flag_a[0]}, 32'd0);
        chk("t5_led",     {31'd0, led_a[0]},        32'd0);
        tick();
        rst_a[0] = 1'b0;
        run_and_check(0, 1'b0, "t5");

        // 6: TEST_LEN=1, init_done low for 1000 cycles
        tick();
        rst_a[1] = 1'b0;
        strobes = 0;
        repeat (1000) begin
            @(negedge clk);
            if (wr_en_a[1] || rd_en_a[1]) strobes++;
        end
        chk("t6_idle_strobes", strobes, 0);
        tick();
        init_done_a[1] = 1'b1;
        run_and_check(1, 1'b0, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
